// File: rtl/voice_allocator.sv
// Three-voice note allocator: assigns note requests to free voices and counts beats down per voice.
// Optional macro VOICE_STEAL_EN: when all voices are busy, steal the voice with the fewest beats left.
module voice_allocator #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic              load_new_note,
    input  logic [NOTE_W-1:0] note_to_load,
    input  logic [DUR_W-1:0]  duration,
    input  logic              beat,
    output logic [2:0]        voice_load,
    output logic [NOTE_W-1:0] voice_note,
    output logic [DUR_W-1:0]  voice_duration,
    output logic [2:0]        voice_busy,
    output logic [2:0]        voice_done,
    output logic              all_idle,
    output logic              note_dropped
);

    localparam logic [DUR_W-1:0] DUR_ZERO = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    logic [DUR_W-1:0]  r_cnt [3];
    logic              r_armed;
    logic [2:0]        r_voice_load;
    logic [NOTE_W-1:0] r_voice_note;
    logic [DUR_W-1:0]  r_voice_duration;
    logic [2:0]        r_voice_done;
    logic              r_note_dropped;

    logic [2:0]        w_free;
    logic              w_req;
    logic              w_tick;
    logic [2:0]        w_sel;
    logic              w_drop;
    logic [DUR_W-1:0]  w_cnt_nxt [3];
    logic [2:0]        w_done_nxt;

`ifdef VOICE_STEAL_EN
    // Smallest remaining count wins; ties resolve toward the lowest index.
    function automatic logic [2:0] steal_pick(input logic [DUR_W-1:0] c0,
                                              input logic [DUR_W-1:0] c1,
                                              input logic [DUR_W-1:0] c2);
        logic [2:0] pick;
        if ((c0 <= c1) && (c0 <= c2)) begin
            pick = 3'b001;
        end else if (c1 <= c2) begin
            pick = 3'b010;
        end else begin
            pick = 3'b100;
        end
        return pick;
    endfunction
`endif

    assign w_free[0]      = (r_cnt[0] == DUR_ZERO);
    assign w_free[1]      = (r_cnt[1] == DUR_ZERO);
    assign w_free[2]      = (r_cnt[2] == DUR_ZERO);
    assign w_tick         = beat & play_enable;
    // r_armed masks the request sampled on the first edge after reset release.
    assign w_req          = r_armed & load_new_note & (duration != DUR_ZERO);

    // Voice selection for the current request, based on registered counter state only.
    always_comb begin
        w_sel  = 3'b000;
        w_drop = 1'b0;
        if (w_req) begin
            if (w_free[0]) begin
                w_sel = 3'b001;
            end else if (w_free[1]) begin
                w_sel = 3'b010;
            end else if (w_free[2]) begin
                w_sel = 3'b100;
            end else begin
`ifdef VOICE_STEAL_EN
                w_sel = steal_pick(r_cnt[0], r_cnt[1], r_cnt[2]);
`else
                w_drop = 1'b1;
`endif
            end
        end else begin
            w_sel = 3'b000;
        end
    end

    // Next counter values and done pulses; a load overrides a beat decrement.
    always_comb begin
        w_done_nxt = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_sel[i]) begin
                w_cnt_nxt[i] = duration;
            end else if (w_tick && !w_free[i]) begin
                w_cnt_nxt[i]  = r_cnt[i] - DUR_ONE;
                w_done_nxt[i] = (r_cnt[i] == DUR_ONE);
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= DUR_ZERO;
            end
            r_armed          <= 1'b0;
            r_voice_load     <= 3'b000;
            r_voice_note     <= {NOTE_W{1'b0}};
            r_voice_duration <= DUR_ZERO;
            r_voice_done     <= 3'b000;
            r_note_dropped   <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_armed        <= 1'b1;
            r_voice_load   <= w_sel;
            r_voice_done   <= w_done_nxt;
            r_note_dropped <= w_drop;
            if (w_sel != 3'b000) begin
                r_voice_note     <= note_to_load;
                r_voice_duration <= duration;
            end else begin
                r_voice_note     <= r_voice_note;
                r_voice_duration <= r_voice_duration;
            end
        end
    end

    assign voice_load     = r_voice_load;
    assign voice_note     = r_voice_note;
    assign voice_duration = r_voice_duration;
    assign voice_done     = r_voice_done;
    assign note_dropped   = r_note_dropped;
    assign voice_busy     = ~w_free;
    assign all_idle       = (w_free == 3'b111);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator; expectations follow VOICE_STEAL_EN when defined.
module tb_voice_allocator;

    logic       clk;
    logic       reset;
    logic       play_enable;
    logic       load_new_note;
    logic [5:0] note_to_load;
    logic [5:0] duration;
    logic       beat;
    logic [2:0] voice_load;
    logic [5:0] voice_note;
    logic [5:0] voice_duration;
    logic [2:0] voice_busy;
    logic [2:0] voice_done;
    logic       all_idle;
    logic       note_dropped;

    int vectors    = 0;
    int miscompares = 0;

    voice_allocator #(.NOTE_W(6), .DUR_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .play_enable    (play_enable),
        .load_new_note  (load_new_note),
        .note_to_load   (note_to_load),
        .duration       (duration),
        .beat           (beat),
        .voice_load     (voice_load),
        .voice_note     (voice_note),
        .voice_duration (voice_duration),
        .voice_busy     (voice_busy),
        .voice_done     (voice_done),
        .all_idle       (all_idle),
        .note_dropped   (note_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] n, input logic [5:0] d);
        load_new_note = 1'b1;
        note_to_load  = n;
        duration      = d;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0; play_enable = 1'b1; load_new_note = 1'b0;
        note_to_load = 6'd0; duration = 6'd0; beat = 1'b0;
        #2;
        check("rst_busy", 32'(voice_busy), 32'd0);
        check("rst_idle", 32'(all_idle), 32'd1);
        check("rst_load", 32'(voice_load), 32'd0);
        check("rst_note", 32'(voice_note), 32'd0);
        check("rst_dur",  32'(voice_duration), 32'd0);
        check("rst_done", 32'(voice_done), 32'd0);
        check("rst_drop", 32'(note_dropped), 32'd0);
        tick();
        tick();

        // Request on the reset-release edge is ignored.
        reset = 1'b1;
        req(6'd5, 6'd7);
        tick();
        load_new_note = 1'b0;
        check("rel_load", 32'(voice_load), 32'd0);
        check("rel_busy", 32'(voice_busy), 32'd0);

        // Basic load and countdown.
        req(6'd10, 6'd3);
        tick();
        load_new_note = 1'b0;
        check("b_load", 32'(voice_load), 32'b001);
        check("b_note", 32'(voice_note), 32'd10);
        check("b_dur",  32'(voice_duration), 32'd3);
        check("b_busy", 32'(voice_busy), 32'b001);
        beat = 1'b1;
        tick();
        check("b_load_1cyc", 32'(voice_load), 32'b000);
        check("b_note_hold", 32'(voice_note), 32'd10);
        tick();
        check("b_done_early", 32'(voice_done), 32'b000);
        tick();
        beat = 1'b0;
        check("b_done", 32'(voice_done), 32'b001);
        check("b_idle", 32'(all_idle), 32'd1);
        tick();
        check("b_done_pulse", 32'(voice_done), 32'b000);

        // Back-to-back requests fill successive voices.
        req(6'd1, 6'd5);
        tick();
        check("bb_load0", 32'(voice_load), 32'b001);
        req(6'd2, 6'd5);
        tick();
        check("bb_load1", 32'(voice_load), 32'b010);
        req(6'd3, 6'd5);
        tick();
        load_new_note = 1'b0;
        check("bb_load2", 32'(voice_load), 32'b100);
        check("bb_note2", 32'(voice_note), 32'd3);
        check("bb_busy", 32'(voice_busy), 32'b111);

        // Reset mid-note clears everything at once, no done pulse.
        reset = 1'b0;
        #1;
        check("mr_busy", 32'(voice_busy), 32'd0);
        check("mr_idle", 32'(all_idle), 32'd1);
        check("mr_note", 32'(voice_note), 32'd0);
        check("mr_done", 32'(voice_done), 32'd0);
        tick();
        check("mr_done2", 32'(voice_done), 32'd0);
        reset = 1'b1;
        tick();

        // All busy (4,2,6) then a fourth request.
        req(6'd4, 6'd4); tick();
        req(6'd5, 6'd2); tick();
        req(6'd6, 6'd6); tick();
        req(6'd7, 6'd9); tick();
        load_new_note = 1'b0;
`ifdef VOICE_STEAL_EN
        check("full_load", 32'(voice_load), 32'b010);
        check("full_dur",  32'(voice_duration), 32'd9);
        check("full_drop", 32'(note_dropped), 32'd0);
`else
        check("full_load", 32'(voice_load), 32'b000);
        check("full_dur",  32'(voice_duration), 32'd6);
        check("full_drop", 32'(note_dropped), 32'd1);
`endif
        check("full_busy", 32'(voice_busy), 32'b111);
        tick();
        check("full_drop_pulse", 32'(note_dropped), 32'd0);

        // Frozen counters with play_enable low, then a rest request.
        play_enable = 1'b0;
        beat = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        beat = 1'b0;
        check("frz_busy", 32'(voice_busy), 32'b111);
        check("frz_done", 32'(voice_done), 32'b000);
        req(6'd9, 6'd0);
        tick();
        load_new_note = 1'b0;
        check("rest_load", 32'(voice_load), 32'b000);
        check("rest_drop", 32'(note_dropped), 32'd0);
        play_enable = 1'b1;
        beat = 1'b1;
        tick();
        tick();
        beat = 1'b0;
`ifdef VOICE_STEAL_EN
        check("frz_done_after", 32'(voice_done), 32'b000);
        check("frz_busy_after", 32'(voice_busy), 32'b111);
`else
        check("frz_done_after", 32'(voice_done), 32'b010);
        check("frz_busy_after", 32'(voice_busy), 32'b101);
`endif

        // Voice 0 at count 1: beat plus request goes to voice 1, undecremented.
        reset_pulse();
        req(6'd11, 6'd2);
        tick();
        load_new_note = 1'b0;
        beat = 1'b1;
        tick();
        req(6'd8, 6'd3);
        tick();
        load_new_note = 1'b0;
        check("same_load", 32'(voice_load), 32'b010);
        check("same_done", 32'(voice_done), 32'b001);
        check("same_busy", 32'(voice_busy), 32'b010);
        tick();
        tick();
        check("same_v1_nodone", 32'(voice_done), 32'b000);
        tick();
        beat = 1'b0;
        check("same_v1_done", 32'(voice_done), 32'b010);
        check("same_idle", 32'(all_idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
